// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit : multi-cycle Moore control FSM for the K&S processor.
//
// Sequences FETCH -> DECODE -> (LOAD|STORE|MOVE|ALU|BRANCH|HALT) and drives
// every datapath control input. All outputs are registered. They are decoded
// from the next state, so they always match the current state one cycle later.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   decoded_instruction     current IR decode (k_and_s_pkg)
//   zero_op, neg_op,
//   unsigned_overflow,
//   signed_overflow         registered datapath flags (sampled in DECODE)
//   branch                  PC source: 1 = address field, 0 = PC+1
//   pc_enable, ir_enable    PC / IR load strobes
//   addr_sel                RAM address: 1 = PC, 0 = address field
//   c_sel                   register write source: 1 = ALU, 0 = RAM
//   operation               ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//   write_reg_enable        register file write strobe
//   flags_reg_enable        flags register load strobe
//   ram_write_enable        RAM write strobe
//   halt                    high while halted
//   instr_count             saturating retired-instruction counter
// -----------------------------------------------------------------------------
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP    = 4'd0,
        I_LOAD   = 4'd1,
        I_STORE  = 4'd2,
        I_MOVE   = 4'd3,
        I_ADD    = 4'd4,
        I_SUB    = 4'd5,
        I_AND    = 4'd6,
        I_OR     = 4'd7,
        I_BRANCH = 4'd8,
        I_BZERO  = 4'd9,
        I_BNZERO = 4'd10,
        I_BNEG   = 4'd11,
        I_BNNEG  = 4'd12,
        I_BOV    = 4'd13,
        I_BNOV   = 4'd14,
        I_HALT   = 4'd15
    } decoded_instruction_type;
endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_STORE  = 3'd3,
        S_MOVE   = 3'd4,
        S_ALU    = 3'd5,
        S_BRANCH = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             branch_q, branch_d;
    logic             pc_enable_q, pc_enable_d;
    logic             ir_enable_q, ir_enable_d;
    logic             addr_sel_q, addr_sel_d;
    logic             c_sel_q, c_sel_d;
    logic [1:0]       operation_q, operation_d;
    logic             write_reg_enable_q, write_reg_enable_d;
    logic             flags_reg_enable_q, flags_reg_enable_d;
    logic             ram_write_enable_q, ram_write_enable_d;
    logic             halt_q, halt_d;
    logic             any_ov;
    logic             retire;

    assign any_ov = signed_overflow | unsigned_overflow;

    // Next-state logic. Unknown decodes fall into the default arm and behave
    // as NOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:   state_d = S_LOAD;
                    I_STORE:  state_d = S_STORE;
                    I_MOVE:   state_d = S_MOVE;
                    I_ADD, I_SUB, I_AND, I_OR: state_d = S_ALU;
                    I_BRANCH: state_d = S_BRANCH;
                    I_BZERO:  state_d = zero_op  ? S_BRANCH : S_FETCH;
                    I_BNZERO: state_d = !zero_op ? S_BRANCH : S_FETCH;
                    I_BNEG:   state_d = neg_op   ? S_BRANCH : S_FETCH;
                    I_BNNEG:  state_d = !neg_op  ? S_BRANCH : S_FETCH;
                    I_BOV:    state_d = any_ov   ? S_BRANCH : S_FETCH;
                    I_BNOV:   state_d = !any_ov  ? S_BRANCH : S_FETCH;
                    I_HALT:   state_d = S_HALT;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode of the next state, so the registered outputs line up with
    // the state they belong to. operation is captured from the decode at the
    // DECODE->ALU edge and therefore stays constant through the ALU cycle.
    always_comb begin
        branch_d           = 1'b0;
        pc_enable_d        = 1'b0;
        ir_enable_d        = 1'b0;
        addr_sel_d         = 1'b1;
        c_sel_d            = 1'b0;
        operation_d        = 2'b00;
        write_reg_enable_d = 1'b0;
        flags_reg_enable_d = 1'b0;
        ram_write_enable_d = 1'b0;
        halt_d             = 1'b0;
        case (state_d)
            S_FETCH:  ir_enable_d = 1'b1;
            S_DECODE: pc_enable_d = 1'b1;
            S_LOAD: begin
                addr_sel_d         = 1'b0;
                write_reg_enable_d = 1'b1;
            end
            S_STORE: begin
                addr_sel_d         = 1'b0;
                ram_write_enable_d = 1'b1;
            end
            S_MOVE: begin
                c_sel_d            = 1'b1;
                write_reg_enable_d = 1'b1;
            end
            S_ALU: begin
                c_sel_d            = 1'b1;
                write_reg_enable_d = 1'b1;
                flags_reg_enable_d = 1'b1;
                case (decoded_instruction)
                    I_ADD:   operation_d = 2'b01;
                    I_SUB:   operation_d = 2'b10;
                    I_AND:   operation_d = 2'b11;
                    default: operation_d = 2'b00;
                endcase
            end
            S_BRANCH: begin
                branch_d    = 1'b1;
                pc_enable_d = 1'b1;
            end
            S_HALT:   halt_d = 1'b1;
            default:  ir_enable_d = 1'b1;
        endcase
    end

    // An instruction retires when any non-FETCH, non-HALT state returns to
    // FETCH, or on the single edge that enters HALT.
    assign retire = ((state_q != S_FETCH) && (state_q != S_HALT) && (state_d == S_FETCH))
                  || ((state_q != S_HALT) && (state_d == S_HALT));

    always_comb begin
        cnt_d = cnt_q;
        if (retire && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= S_FETCH;
            cnt_q              <= '0;
            branch_q           <= 1'b0;
            pc_enable_q        <= 1'b0;
            ir_enable_q        <= 1'b1;
            addr_sel_q         <= 1'b1;
            c_sel_q            <= 1'b0;
            operation_q        <= 2'b00;
            write_reg_enable_q <= 1'b0;
            flags_reg_enable_q <= 1'b0;
            ram_write_enable_q <= 1'b0;
            halt_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            cnt_q              <= cnt_d;
            branch_q           <= branch_d;
            pc_enable_q        <= pc_enable_d;
            ir_enable_q        <= ir_enable_d;
            addr_sel_q         <= addr_sel_d;
            c_sel_q            <= c_sel_d;
            operation_q        <= operation_d;
            write_reg_enable_q <= write_reg_enable_d;
            flags_reg_enable_q <= flags_reg_enable_d;
            ram_write_enable_q <= ram_write_enable_d;
            halt_q             <= halt_d;
        end
    end

    assign branch           = branch_q;
    assign pc_enable        = pc_enable_q;
    assign ir_enable        = ir_enable_q;
    assign addr_sel         = addr_sel_q;
    assign c_sel            = c_sel_q;
    assign operation        = operation_q;
    assign write_reg_enable = write_reg_enable_q;
    assign flags_reg_enable = flags_reg_enable_q;
    assign ram_write_enable = ram_write_enable_q;
    assign halt             = halt_q;
    assign instr_count      = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit : self-checking bench for control_unit (CNT_W = 3 so that
// saturation is reachable quickly). A behavioural model gives, per
// instruction, the cycle count and the expected output vector of each cycle.
// It also tracks the expected retired-instruction count.
// -----------------------------------------------------------------------------
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // bit positions in the packed output vector
    localparam int BR = 10, PC = 9, IR = 8, AS = 7, CS = 6, WR = 3, FL = 2, RW = 1, HT = 0;

    logic                    clk = 1'b0;
    logic                    rst_n;
    decoded_instruction_type instr;
    logic                    zero_op, neg_op, unsigned_overflow, signed_overflow;
    logic                    branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable, flags_reg_enable, ram_write_enable, halt;
    logic [CNT_W-1:0]        instr_count;

    int          total = 0;
    int          bad   = 0;
    int          model_cnt;
    int          ncyc_m;
    logic [10:0] obs [3];

    control_unit #(.CNT_W(CNT_W)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .decoded_instruction (instr),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt),
        .instr_count         (instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] outs_now();
        return {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halt};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic model_taken(decoded_instruction_type i, logic z, logic n,
                                         logic uo, logic so);
        case (i)
            I_BRANCH: return 1'b1;
            I_BZERO:  return z;
            I_BNZERO: return !z;
            I_BNEG:   return n;
            I_BNNEG:  return !n;
            I_BOV:    return uo || so;
            I_BNOV:   return !(uo || so);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic int model_cycles(decoded_instruction_type i, logic z, logic n,
                                        logic uo, logic so);
        if (i inside {I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT}) return 3;
        if (model_taken(i, z, n, uo, so)) return 3;
        return 2;
    endfunction

    // Expected outputs in cycle c (0 = fetch, 1 = decode, 2 = execute).
    function automatic logic [10:0] model_out(decoded_instruction_type i, int c);
        logic [10:0] o;
        o     = '0;
        o[AS] = 1'b1;
        if (c == 0) begin
            o[IR] = 1'b1;
        end else if (c == 1) begin
            o[PC] = 1'b1;
        end else begin
            case (i)
                I_LOAD:  begin o[AS] = 1'b0; o[WR] = 1'b1; end
                I_STORE: begin o[AS] = 1'b0; o[RW] = 1'b1; end
                I_MOVE:  begin o[CS] = 1'b1; o[WR] = 1'b1; end
                I_ADD, I_SUB, I_AND, I_OR: begin
                    o[CS] = 1'b1; o[WR] = 1'b1; o[FL] = 1'b1;
                    o[5:4] = (i == I_ADD) ? 2'b01 : (i == I_SUB) ? 2'b10 :
                             (i == I_AND) ? 2'b11 : 2'b00;
                end
                I_HALT:  o[HT] = 1'b1;
                default: begin o[BR] = 1'b1; o[PC] = 1'b1; end
            endcase
        end
        return o;
    endfunction

    // Drive one instruction from a FETCH cycle (entered at a negedge), record
    // the outputs of each of its cycles, and return at the negedge of the next
    // FETCH (or one cycle into HALT).
    task automatic run_instr(input decoded_instruction_type i, input logic z, input logic n,
                             input logic uo, input logic so);
        instr = i; zero_op = z; neg_op = n; unsigned_overflow = uo; signed_overflow = so;
        ncyc_m = model_cycles(i, z, n, uo, so);
        obs[0] = outs_now();
        @(posedge clk); @(negedge clk);
        obs[1] = outs_now();
        @(posedge clk); @(negedge clk);
        if (ncyc_m == 3) begin
            obs[2] = outs_now();
            @(posedge clk); @(negedge clk);
        end
        model_cnt = (model_cnt < CNT_MAX) ? model_cnt + 1 : CNT_MAX;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [10:0] fetch_o;
        fetch_o = model_out(I_NOP, 0);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (outs_now() !== fetch_o || instr_count !== '0) begin
            bad++;
            $display("FAIL reset_hold outs=%b cnt=%0d exp outs=%b cnt=0", outs_now(), instr_count, fetch_o);
        end
        rst_n = 1'b1;
        model_cnt = 0;
        // reach the middle of an ADD, then reset asynchronously
        instr = I_ADD;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        total++;
        if (write_reg_enable !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_alu wr=%b exp=1", write_reg_enable);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (outs_now() !== fetch_o || instr_count !== '0) begin
            bad++;
            $display("FAIL reset_async outs=%b cnt=%0d exp outs=%b cnt=0", outs_now(), instr_count, fetch_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        total++;
        if (outs_now() !== fetch_o || instr_count !== '0 || halt !== 1'b0) begin
            bad++;
            $display("FAIL reset_release outs=%b cnt=%0d exp outs=%b cnt=0", outs_now(), instr_count, fetch_o);
        end
    endtask

    task automatic test_alu();
        decoded_instruction_type seq [4];
        seq = '{I_ADD, I_SUB, I_AND, I_OR};
        do_reset();
        foreach (seq[k]) begin
            run_instr(seq[k], $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 1), $urandom_range(0, 1));
            total++;
            if (ncyc_m != 3) begin
                bad++;
                $display("FAIL alu_cycles %s got=%0d exp=3", seq[k].name(), ncyc_m);
            end
            for (int c = 0; c < ncyc_m; c++) begin
                total++;
                if (obs[c] !== model_out(seq[k], c)) begin
                    bad++;
                    $display("FAIL alu_%s cyc%0d got=%b exp=%b", seq[k].name(), c, obs[c], model_out(seq[k], c));
                end
            end
        end
        total++;
        if (instr_count !== CNT_W'(4)) begin
            bad++;
            $display("FAIL alu_count got=%0d exp=4", instr_count);
        end
    endtask

    task automatic test_mem_move();
        decoded_instruction_type seq [3];
        seq = '{I_LOAD, I_STORE, I_MOVE};
        foreach (seq[k]) begin
            run_instr(seq[k], 1'b0, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < ncyc_m; c++) begin
                total++;
                if (obs[c] !== model_out(seq[k], c)) begin
                    bad++;
                    $display("FAIL mem_%s cyc%0d got=%b exp=%b", seq[k].name(), c, obs[c], model_out(seq[k], c));
                end
            end
            total++;
            if (instr_count !== CNT_W'(model_cnt)) begin
                bad++;
                $display("FAIL mem_count_%s got=%0d exp=%0d", seq[k].name(), instr_count, model_cnt);
            end
        end
    endtask

    task automatic test_branches();
        decoded_instruction_type br [6];
        decoded_instruction_type i;
        logic f, z, n, uo, so;
        br = '{I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            for (int v = 0; v < 2; v++) begin
                i  = br[k];
                f  = v[0];
                z  = $urandom_range(0, 1); n = $urandom_range(0, 1);
                uo = $urandom_range(0, 1); so = $urandom_range(0, 1);
                if (k < 2) z = f; else if (k < 4) n = f; else begin uo = f; so = f; end
                run_instr(i, z, n, uo, so);
                for (int c = 0; c < ncyc_m; c++) begin
                    total++;
                    if (obs[c] !== model_out(i, c)) begin
                        bad++;
                        $display("FAIL br_%s_f%0d cyc%0d got=%b exp=%b", i.name(), f, c, obs[c], model_out(i, c));
                    end
                end
                total++;
                if (outs_now() !== model_out(I_NOP, 0)) begin
                    bad++;
                    $display("FAIL br_%s_f%0d_refetch got=%b exp=%b", i.name(), f, outs_now(), model_out(I_NOP, 0));
                end
            end
        end
        // BOV with one overflow flag at a time, then both
        for (int m = 1; m < 4; m++) begin
            run_instr(I_BOV, 1'b0, 1'b0, m[0], m[1]);
            total++;
            if (ncyc_m != 3 || obs[2] !== model_out(I_BOV, 2)) begin
                bad++;
                $display("FAIL bov_uo%0d_so%0d got=%b exp=%b", m[0], m[1], obs[2], model_out(I_BOV, 2));
            end
        end
        total++;
        if (instr_count !== CNT_W'(model_cnt)) begin
            bad++;
            $display("FAIL br_count got=%0d exp=%0d", instr_count, model_cnt);
        end
    endtask

    task automatic test_random();
        decoded_instruction_type i;
        logic z, n, uo, so;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            i  = decoded_instruction_type'($urandom_range(0, 14));
            z  = $urandom_range(0, 1); n = $urandom_range(0, 1);
            uo = $urandom_range(0, 1); so = $urandom_range(0, 1);
            run_instr(i, z, n, uo, so);
            for (int c = 0; c < ncyc_m; c++) begin
                total++;
                if (obs[c] !== model_out(i, c)) begin
                    bad++;
                    $display("FAIL rnd%0d_%s cyc%0d got=%b exp=%b", t, i.name(), c, obs[c], model_out(i, c));
                end
            end
            total++;
            if (instr_count !== CNT_W'(model_cnt)) begin
                bad++;
                $display("FAIL rnd%0d_count got=%0d exp=%0d", t, instr_count, model_cnt);
            end
        end
    endtask

    task automatic test_halt_sat();
        // unsaturated halt counts once on entry
        do_reset();
        run_instr(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (instr_count !== CNT_W'(model_cnt) || halt !== 1'b1) begin
            bad++;
            $display("FAIL halt_entry cnt=%0d halt=%b exp cnt=%0d halt=1", instr_count, halt, model_cnt);
        end
        // saturation, then halt held for 20 cycles
        do_reset();
        for (int k = 0; k < 9; k++) run_instr(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        total++;
        if (instr_count !== CNT_W'(CNT_MAX)) begin
            bad++;
            $display("FAIL sat_count got=%0d exp=%0d", instr_count, CNT_MAX);
        end
        run_instr(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (obs[c] !== model_out(I_HALT, c)) begin
                bad++;
                $display("FAIL halt_seq cyc%0d got=%b exp=%b", c, obs[c], model_out(I_HALT, c));
            end
        end
        for (int k = 0; k < 20; k++) begin
            instr = decoded_instruction_type'($urandom_range(0, 15));
            @(posedge clk); @(negedge clk);
            total++;
            if (outs_now() !== model_out(I_HALT, 2) || instr_count !== CNT_W'(CNT_MAX)) begin
                bad++;
                $display("FAIL halt_hold%0d outs=%b cnt=%0d exp outs=%b cnt=%0d",
                         k, outs_now(), instr_count, model_out(I_HALT, 2), CNT_MAX);
            end
        end
        // reset pulse resumes normal fetch
        do_reset();
        run_instr(I_MOVE, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            total++;
            if (obs[c] !== model_out(I_MOVE, c)) begin
                bad++;
                $display("FAIL resume cyc%0d got=%b exp=%b", c, obs[c], model_out(I_MOVE, c));
            end
        end
        total++;
        if (instr_count !== CNT_W'(1) || halt !== 1'b0) begin
            bad++;
            $display("FAIL resume_count cnt=%0d halt=%b exp cnt=1 halt=0", instr_count, halt);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr = I_NOP;
        zero_op = 1'b0; neg_op = 1'b0; unsigned_overflow = 1'b0; signed_overflow = 1'b0;
        model_cnt = 0;
        ncyc_m = 0;
        test_reset();
        test_alu();
        test_mem_move();
        test_branches();
        test_random();
        test_halt_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle Moore control FSM for the K&S processor. It sits directly upstream of `data_path` and drives every datapath control input. It sequences fetch, decode and execute from `decoded_instruction` and the registered flags. It also drives the RAM write strobe, a halt indicator and a saturating retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 16: width of `instr_count`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `decoded_instruction`  in  `decoded_instruction_type` (`k_and_s_pkg`)  current IR decode.
- `zero_op`, `neg_op`, `unsigned_overflow`, `signed_overflow`  in  1 each  registered datapath flags.
- `branch`  out  1  PC load source: 1 = instruction address field, 0 = PC+1.
- `pc_enable`  out  1  PC update strobe.
- `ir_enable`  out  1  IR load strobe.
- `addr_sel`  out  1  RAM address source: 1 = PC, 0 = instruction address field.
- `c_sel`  out  1  register write source: 1 = ALU, 0 = RAM data.
- `operation`  out  2  ALU operation: 00 = OR, 01 = ADD, 10 = SUB, 11 = AND.
- `write_reg_enable`  out  1  register file write strobe.
- `flags_reg_enable`  out  1  flags register load strobe.
- `ram_write_enable`  out  1  RAM write strobe; the datapath `data_out` is written to the address on `ram_addr`.
- `halt`  out  1  high while the core is halted.
- `instr_count`  out  `CNT_W`  count of completed instructions.

## Operation
- States: FETCH, DECODE, LOAD, STORE, MOVE, ALU, BRANCH, HALT.
- Outputs are a decode of the current state only. Any output not listed for a state is 0, except `addr_sel`, which defaults to 1.
- FETCH:
  - Outputs: `addr_sel`=1, `ir_enable`=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: `pc_enable`=1, `branch`=0, so PC <= PC+1.
  - Next state by `decoded_instruction`:
    - I_LOAD → LOAD; I_STORE → STORE; I_MOVE → MOVE.
    - I_ADD / I_SUB / I_AND / I_OR → ALU.
    - I_BRANCH → BRANCH.
    - Conditional branches → BRANCH if the condition holds, else FETCH.
    - I_HALT → HALT; I_NOP and any other value → FETCH.
- Branch conditions, evaluated on the flag values present in DECODE:
  - BZERO: `zero_op`=1. BNZERO: `zero_op`=0.
  - BNEG: `neg_op`=1. BNNEG: `neg_op`=0.
  - BOV: `signed_overflow` | `unsigned_overflow` = 1. BNOV: that OR = 0.
- LOAD: `addr_sel`=0, `c_sel`=0, `write_reg_enable`=1; next FETCH.
- STORE: `addr_sel`=0, `ram_write_enable`=1; next FETCH.
- MOVE: `operation`=00 (A|A = A), `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=0; next FETCH.
- ALU:
  - `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=1; next FETCH.
  - `operation` mapping: ADD=01, SUB=10, AND=11, OR=00.
  - `operation` is derived from `decoded_instruction` and held stable for the whole state.
- BRANCH: `branch`=1, `pc_enable`=1, so PC <= address field, overriding the DECODE increment; next FETCH.
- HALT: all strobes 0, `halt`=1; the state is absorbing and is left only by reset.
- `instr_count`:
  - Increments by 1 on each clock edge where the FSM leaves DECODE, LOAD, STORE, MOVE, ALU or BRANCH into FETCH.
  - Also increments once on entry to HALT.
  - Saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous, `rst_n`=0): state = FETCH, `instr_count`=0, `halt`=0.
  - Outputs during and immediately after reset are the FETCH values: `addr_sel`=1, `ir_enable`=1, all others 0.
  - Deasserting reset mid-instruction always restarts at FETCH. No write strobe is ever asserted while `rst_n`=0.
- Cycles per instruction:
  - NOP, untaken conditional branch: 2 (FETCH, DECODE).
  - LOAD, STORE, MOVE, ALU ops, taken branch: 3.
  - HALT: 2 cycles to reach the HALT state, then held.
- Flag hazard: an ALU op writes flags at the end of its ALU cycle. A conditional branch immediately following samples them in its DECODE, 2 cycles later, so no stall is needed.
- `ram_write_enable` and `write_reg_enable` are each high for exactly one cycle per instruction and never together.
- At most one of `ir_enable`, `write_reg_enable` and `ram_write_enable` is high in any cycle.
- Unknown or X decode in DECODE is treated as NOP.

## Test plan
- Reset and fetch: assert `rst_n`=0 mid-ALU state, then release.
  - Required: FETCH outputs (`ir_enable`=1, `addr_sel`=1) on the first cycle, `instr_count`=0, `halt`=0.
- ALU sequence: drive I_ADD, then I_SUB, I_AND, I_OR in turn.
  - Required: 3 cycles each; `operation` = 01, 10, 11, 00 in the ALU state, with `c_sel`=1, `write_reg_enable`=1, `flags_reg_enable`=1.
  - `instr_count` reaches 4.
- LOAD, STORE, MOVE:
  - LOAD: `addr_sel`=0, `c_sel`=0, `write_reg_enable`=1 in cycle 3.
  - STORE: `ram_write_enable`=1, `write_reg_enable`=0.
  - MOVE: `operation`=00, `flags_reg_enable`=0.
- Conditional branches: exercise each of the 6 branch types with its flag set to 1 and to 0.
  - Example: BZERO with `zero_op`=1 → BRANCH state, `branch`=1 and `pc_enable`=1 in cycle 3.
  - Example: BZERO with `zero_op`=0 → back to FETCH after 2 cycles, `branch` never 1.
  - BOV must be taken for `unsigned_overflow` only, for `signed_overflow` only, and for both.
- Halt and saturation, with `CNT_W`=3:
  - Run 9 NOPs: `instr_count` sticks at 7.
  - Then I_HALT: `halt`=1 from cycle 3 onward and all strobes 0 for 20 cycles.
  - Then `rst_n` pulse: normal fetch resumes.
